// File: rtl/burst_pkg.sv
// Shared widths, state encoding and small helpers for the burst responder.
package burst_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2
    } state_e;

    // Word pointers wrap modulo DEPTH through natural ADDR_W-bit overflow.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_ONE;
    endfunction

    function automatic logic [LEN_W-1:0] len_dec(input logic [LEN_W-1:0] len);
        return len - LEN_ONE;
    endfunction

endpackage

// File: rtl/burst_mem.sv
// 16 x 32-bit word store: one synchronous write port, one combinational read
// port, and an asynchronous active-low clear of every word.
module burst_mem
    import burst_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage update; reset wipes the whole array so aborted bursts leave no trace.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read so a read beat appears in the same cycle as its pointer.
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/burst_responder.sv
// Burst responder: accepts burst-write and burst-read commands against a
// 16-word store, streaming one beat per non-stalled cycle.
module burst_responder
    import burst_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [ADDR_W-1:0] io_address,
    input  logic [LEN_W-1:0]  io_length,
    input  logic [DATA_W-1:0] io_wdata,
    input  logic              io_stall,
    output logic              io_ready,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_rddatavalid
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;

    logic              len_nz;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_rdata;

    assign len_nz = (io_length != '0);

    burst_mem u_mem (
        .clk_i   (clock),
        .rst_ni  (reset),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (io_wdata),
        .raddr_i (ptr_q),
        .rdata_o (mem_rdata)
    );

    // State, pointer and remaining-beat registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state: command decode in idle, beat counting in the burst states.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle: begin
                if (io_ready && len_nz) begin
                    // Write wins over a simultaneous read; beat 0 is written this edge.
                    if (io_wr) begin
                        if (io_length != LEN_ONE) begin
                            state_d = StWrite;
                            ptr_d   = addr_inc(io_address);
                            rem_d   = len_dec(io_length);
                        end
                    end else if (io_rd) begin
                        state_d = StRead;
                        ptr_d   = io_address;
                        rem_d   = io_length;
                    end
                end
            end
            StWrite: begin
                if (io_ready) begin
                    ptr_d = addr_inc(ptr_q);
                    rem_d = len_dec(rem_q);
                    if (rem_q == LEN_ONE) begin
                        state_d = StIdle;
                    end
                end
            end
            StRead: begin
                if (!io_stall) begin
                    ptr_d = addr_inc(ptr_q);
                    rem_d = len_dec(rem_q);
                    if (rem_q == LEN_ONE) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs and store write strobe; everything is forced quiet while reset is low.
    always_comb begin
        io_ready       = reset && (state_q != StRead) && !io_stall;
        io_rddatavalid = reset && (state_q == StRead) && !io_stall;
        io_rdata       = io_rddatavalid ? mem_rdata : '0;
        mem_we         = io_ready &&
                         (((state_q == StIdle) && io_wr && len_nz) || (state_q == StWrite));
        mem_waddr      = (state_q == StIdle) ? io_address : ptr_q;
    end

endmodule

// File: tb/tb_burst_responder.sv
// Self-checking bench for burst_responder: directed scenarios followed by
// randomized traffic compared against a queue-based burst model.
module tb_burst_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_wr;
    logic        io_rd;
    logic [3:0]  io_address;
    logic [3:0]  io_length;
    logic [31:0] io_wdata;
    logic        io_stall;
    logic        io_ready;
    logic [31:0] io_rdata;
    logic        io_rddatavalid;

    burst_responder dut (
        .clock          (clock),
        .reset          (reset),
        .io_wr          (io_wr),
        .io_rd          (io_rd),
        .io_address     (io_address),
        .io_length      (io_length),
        .io_wdata       (io_wdata),
        .io_stall       (io_stall),
        .io_ready       (io_ready),
        .io_rdata       (io_rdata),
        .io_rddatavalid (io_rddatavalid)
    );

    always #5 clock = ~clock;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: word array, addresses still owed write beats, and
    // read data still owed to the bus.
    logic [31:0] mem_m [16];
    int          wr_addr_q [$];
    logic [31:0] rd_data_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive after the falling edge, check, advance the model.
    task automatic cycle(input string tag, input logic rst, input logic wr, input logic rd,
                         input logic [3:0] addr, input logic [3:0] len,
                         input logic [31:0] wd, input logic st);
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_data;
        reset      = rst;
        io_wr      = wr;
        io_rd      = rd;
        io_address = addr;
        io_length  = len;
        io_wdata   = wd;
        io_stall   = st;
        #1;
        if (!rst) begin
            foreach (mem_m[i]) mem_m[i] = '0;
            wr_addr_q.delete();
            rd_data_q.delete();
            e_ready = 1'b0;
            e_valid = 1'b0;
            e_data  = '0;
        end else begin
            e_ready = (rd_data_q.size() == 0) && !st;
            e_valid = (rd_data_q.size() != 0) && !st;
            e_data  = e_valid ? rd_data_q[0] : 32'h0;
        end
        check_val({tag, "_ready"}, {31'b0, io_ready}, {31'b0, e_ready});
        check_val({tag, "_valid"}, {31'b0, io_rddatavalid}, {31'b0, e_valid});
        check_val({tag, "_rdata"}, io_rdata, e_data);
        if (rst) begin
            if (e_valid) begin
                void'(rd_data_q.pop_front());
            end else if (e_ready) begin
                if (wr_addr_q.size() != 0) begin
                    mem_m[wr_addr_q.pop_front()] = wd;
                end else if (wr && len != 0) begin
                    for (int i = 0; i < int'(len); i++) wr_addr_q.push_back((int'(addr) + i) % 16);
                    mem_m[wr_addr_q.pop_front()] = wd;
                end else if (rd && len != 0) begin
                    for (int i = 0; i < int'(len); i++) rd_data_q.push_back(mem_m[(int'(addr) + i) % 16]);
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, $urandom, 1'b0);
    endtask

    initial begin
        logic [31:0] stall_pat;
        reset = 1'b0; io_wr = 1'b0; io_rd = 1'b0; io_address = '0;
        io_length = '0; io_wdata = '0; io_stall = 1'b0;
        @(negedge clock);

        // Reset state, even with commands and stall toggling.
        cycle("rst", 1'b0, 1'b1, 1'b1, 4'd2, 4'd3, 32'h1234, 1'b0);
        cycle("rst", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 1'b1);
        idle("idle", 1);

        // Write 6..9, then read them back.
        cycle("wr6", 1'b1, 1'b1, 1'b0, 4'd6, 4'd4, 32'hAAAA_0001, 1'b0);
        cycle("wr6", 1'b1, 1'b0, 1'b1, 4'd0, 4'd9, 32'hBBBB_0002, 1'b0);
        cycle("wr6", 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 32'hCCCC_0003, 1'b0);
        cycle("wr6", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'hDDDD_0004, 1'b0);
        cycle("rd6", 1'b1, 1'b0, 1'b1, 4'd6, 4'd4, 32'h0, 1'b0);
        cycle("rd6", 1'b1, 1'b1, 1'b0, 4'd0, 4'd2, 32'hDEAD, 1'b0);
        idle("rd6", 4);

        // Wrap past word 15.
        cycle("wr14", 1'b1, 1'b1, 1'b0, 4'd14, 4'd3, 32'd1, 1'b0);
        cycle("wr14", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'd2, 1'b0);
        cycle("wr14", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'd3, 1'b0);
        cycle("rd14", 1'b1, 1'b0, 1'b1, 4'd14, 4'd3, 32'h0, 1'b0);
        idle("rd14", 4);

        // Read with a two-cycle stall gap on the third beat.
        cycle("rdst", 1'b1, 1'b0, 1'b1, 4'd6, 4'd4, 32'h0, 1'b0);
        stall_pat = 32'b0000_1100;
        for (int i = 0; i < 7; i++)
            cycle("rdst", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, stall_pat[i]);

        // Simultaneous wr/rd (write wins), zero-length commands, read back.
        cycle("wrrd", 1'b1, 1'b1, 1'b1, 4'd3, 4'd1, 32'd5, 1'b0);
        idle("wrrd", 1);
        cycle("len0", 1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 32'd9, 1'b0);
        cycle("len0", 1'b1, 1'b0, 1'b1, 4'd3, 4'd0, 32'd0, 1'b0);
        cycle("rd3", 1'b1, 1'b0, 1'b1, 4'd3, 4'd1, 32'h0, 1'b0);
        idle("rd3", 2);

        // Stall while idle blocks a command.
        cycle("stid", 1'b1, 1'b1, 1'b0, 4'd0, 4'd2, 32'h77, 1'b1);
        idle("stid", 1);

        // Reset in the middle of a write burst, then read back zeros.
        cycle("wrrst", 1'b1, 1'b1, 1'b0, 4'd6, 4'd4, 32'h1111_1111, 1'b0);
        cycle("wrrst", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h2222_2222, 1'b0);
        cycle("wrrst", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'h3333_3333, 1'b0);
        cycle("wrrst", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'h4444_4444, 1'b0);
        idle("post", 1);
        cycle("rdrst", 1'b1, 1'b0, 1'b1, 4'd6, 4'd2, 32'h0, 1'b0);
        idle("rdrst", 3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle("rand", ($urandom % 400) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
                  4'($urandom), 4'($urandom), $urandom, ($urandom % 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
